// File: rtl/fifo_tree_sched.sv
// fifo_tree_sched
//   Feeds a clause FIFO tree from NUM_REQ batch requesters and drains the tree
//   into a single-clause consumer stream.
//   Write side: round-robin grant in IDLE, fixed 5-cycle WRITE burst with the
//   registered batch held on tree_clauses_o/tree_valid_o, then an optional
//   1-cycle CLEAR that pulses tree_cof_o when the tree reported overflow.
//   Read side: independent of the write FSM; keeps a 2-entry output FIFO fed by
//   tree_rd_en_o (1-cycle read latency) so a ready consumer sees 1 clause/cycle.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   req_clauses_i/req_mask_i     per-requester batch and clause-valid mask
//   req_valid_i/req_ready_o      batch handshake (ready is one-hot or zero)
//   tree_clauses_o/tree_valid_o  batch and mask driven to the tree
//   tree_wr_en_o                 write-start pulse (first WRITE cycle)
//   tree_rd_en_o/tree_clause_i   tree read request and data (next cycle)
//   tree_empty_i, tree_of_i      tree status
//   tree_cof_o                   clear-overflow pulse
//   out_clause_o/out_valid_o/out_ready_i  consumer stream
//   of_count_o                   saturating count of overflow rising edges
//   busy_o                       write FSM not idle
module fifo_tree_sched #(
   parameter int CLAUSE_COUNT = 20,
   parameter int CLAUSE_WIDTH = 36,
   parameter int NUM_REQ      = 4,
   parameter int OF_CNT_WIDTH = 16
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic [NUM_REQ*CLAUSE_COUNT*CLAUSE_WIDTH-1:0] req_clauses_i,
   input  logic [NUM_REQ*CLAUSE_COUNT-1:0]              req_mask_i,
   input  logic [NUM_REQ-1:0]                           req_valid_i,
   output logic [NUM_REQ-1:0]                           req_ready_o,
   output logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0]         tree_clauses_o,
   output logic [CLAUSE_COUNT-1:0]                      tree_valid_o,
   output logic                                         tree_wr_en_o,
   output logic                                         tree_rd_en_o,
   input  logic                                         tree_empty_i,
   input  logic                                         tree_of_i,
   output logic                                         tree_cof_o,
   input  logic [CLAUSE_WIDTH-1:0]                      tree_clause_i,
   output logic [CLAUSE_WIDTH-1:0]                      out_clause_o,
   output logic                                         out_valid_o,
   input  logic                                         out_ready_i,
   output logic [OF_CNT_WIDTH-1:0]                      of_count_o,
   output logic                                         busy_o
);
   localparam int BW = CLAUSE_COUNT * CLAUSE_WIDTH;
   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

   state_t                  state_q, state_d;
   logic [RW-1:0]           rr_q, rr_nxt;
   logic [2:0]              wcnt_q;
   logic                    of_seen_q;   // overflow observed at any point of the current WRITE
   logic                    of_d1_q;
   logic [OF_CNT_WIDTH-1:0] of_count_q;
   logic [BW-1:0]           batch_q;
   logic [CLAUSE_COUNT-1:0] mask_q;

   // ---------------------------------------------------------------- grant
   logic [BW-1:0]           req_batch [NUM_REQ];
   logic [CLAUSE_COUNT-1:0] req_mask  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_batch[g] = req_clauses_i[g*BW +: BW];
      assign req_mask[g]  = req_mask_i[g*CLAUSE_COUNT +: CLAUSE_COUNT];
   end

   logic          gnt_found;
   logic [RW-1:0] gnt_idx;
   logic [RW:0]   cand;
   logic [RW:0]   rr_inc;
   logic          grant;

   // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_q} + (RW+1)'(k);
         if (cand >= (RW+1)'(NUM_REQ)) cand = cand - (RW+1)'(NUM_REQ);
         if (!gnt_found && req_valid_i[cand[RW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[RW-1:0];
         end
      end
   end

   // rst_i gates the combinational paths so every output is 0 under reset.
   assign grant  = ~rst_i & (state_q == S_IDLE) & ~tree_of_i & gnt_found;
   assign rr_inc = {1'b0, gnt_idx} + (RW+1)'(1);
   assign rr_nxt = (rr_inc >= (RW+1)'(NUM_REQ)) ? '0 : rr_inc[RW-1:0];

   always_comb begin
      req_ready_o = '0;
      if (grant) req_ready_o[gnt_idx] = 1'b1;
   end

   // ---------------------------------------------------------------- write FSM
   always_comb begin
      state_d      = state_q;
      tree_wr_en_o = 1'b0;
      tree_cof_o   = 1'b0;
      busy_o       = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (tree_of_i)                         state_d = S_CLEAR;
            else if (grant && |req_mask[gnt_idx])  state_d = S_WRITE;
         end
         S_WRITE: begin
            tree_wr_en_o = (wcnt_q == 3'd0);
            // Overflow never cuts a burst short; it only selects the exit.
            if (wcnt_q == 3'd4) state_d = (tree_of_i || of_seen_q) ? S_CLEAR : S_IDLE;
         end
         S_CLEAR: begin
            tree_cof_o = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         rr_q       <= '0;
         wcnt_q     <= '0;
         of_seen_q  <= 1'b0;
         of_d1_q    <= 1'b0;
         of_count_q <= '0;
         batch_q    <= '0;
         mask_q     <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            batch_q <= req_batch[gnt_idx];
            mask_q  <= req_mask[gnt_idx];
            rr_q    <= rr_nxt;
         end
         if (state_q == S_WRITE) begin
            wcnt_q <= wcnt_q + 3'd1;
            if (tree_of_i) of_seen_q <= 1'b1;
         end else begin
            wcnt_q    <= '0;
            of_seen_q <= 1'b0;
         end
         of_d1_q <= tree_of_i;
         if (tree_of_i && !of_d1_q && (of_count_q != '1)) of_count_q <= of_count_q + 1'b1;
      end
   end

   assign tree_clauses_o = batch_q;
   assign tree_valid_o   = mask_q;
   assign of_count_o     = of_count_q;

   // ---------------------------------------------------------------- read side
   logic [1:0]              occ_q;
   logic                    inflight_q;  // read issued last cycle, data arrives now
   logic                    wp_q, rp_q;
   logic [CLAUSE_WIDTH-1:0] mem_q [2];
   logic                    pop;
   logic [2:0]              pending;

   assign out_valid_o  = (occ_q != 2'd0);
   assign pop          = out_valid_o & out_ready_i;
   // Slots already spoken for; a pop this cycle frees one for a new read.
   assign pending      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign tree_rd_en_o = ~rst_i & ~tree_empty_i & (pending < 3'd2);
   assign out_clause_o = out_valid_o ? mem_q[rp_q] : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
      end else begin
         inflight_q <= tree_rd_en_o;
         if (inflight_q) wp_q <= ~wp_q;
         if (pop)        rp_q <= ~rp_q;
         occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (inflight_q) mem_q[wp_q] <= tree_clause_i;
   end

endmodule

// File: tb/tb_fifo_tree_sched.sv
module tb_fifo_tree_sched;
   localparam int CC = 4;
   localparam int CW = 8;
   localparam int NR = 4;
   localparam int BW = CC * CW;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [NR*BW-1:0] req_clauses;
   logic [NR*CC-1:0] req_mask;
   logic [NR-1:0]    req_valid, req_ready;
   logic [BW-1:0]    tree_clauses;
   logic [CC-1:0]    tree_valid;
   logic             tree_wr_en, tree_rd_en, tree_empty, tree_of, tree_cof;
   logic [CW-1:0]    tree_clause = '0;
   logic [CW-1:0]    out_clause;
   logic             out_valid, out_ready;
   logic [15:0]      of_count;
   logic             busy;

   fifo_tree_sched #(.CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW), .NUM_REQ(NR), .OF_CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_clauses_i(req_clauses), .req_mask_i(req_mask), .req_valid_i(req_valid),
      .req_ready_o(req_ready), .tree_clauses_o(tree_clauses), .tree_valid_o(tree_valid),
      .tree_wr_en_o(tree_wr_en), .tree_rd_en_o(tree_rd_en), .tree_empty_i(tree_empty),
      .tree_of_i(tree_of), .tree_cof_o(tree_cof), .tree_clause_i(tree_clause),
      .out_clause_o(out_clause), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .of_count_o(of_count), .busy_o(busy)
   );

   // Narrow overflow counter instance for the saturation check.
   logic          tree_of2;
   logic [NR-1:0] req_ready2;
   logic [BW-1:0] tree_clauses2;
   logic [CC-1:0] tree_valid2;
   logic          tree_wr_en2, tree_rd_en2, tree_cof2, out_valid2, busy2;
   logic [CW-1:0] out_clause2;
   logic [1:0]    of_count2;

   fifo_tree_sched #(.CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW), .NUM_REQ(NR), .OF_CNT_WIDTH(2)) dut2 (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_clauses_i('0), .req_mask_i('0), .req_valid_i('0),
      .req_ready_o(req_ready2), .tree_clauses_o(tree_clauses2), .tree_valid_o(tree_valid2),
      .tree_wr_en_o(tree_wr_en2), .tree_rd_en_o(tree_rd_en2), .tree_empty_i(1'b1),
      .tree_of_i(tree_of2), .tree_cof_o(tree_cof2), .tree_clause_i('0),
      .out_clause_o(out_clause2), .out_valid_o(out_valid2), .out_ready_i(1'b0),
      .of_count_o(of_count2), .busy_o(busy2)
   );

   // Tree model: tree_load sets the number of stored clauses; reads return
   // 0xA0, 0xA1, ... one cycle after tree_rd_en.
   int tree_cnt  = 0;
   int tree_load = 0;
   int rd_idx    = 0;
   int rd_pulses = 0;
   int rd_empty  = 0;
   assign tree_empty = (tree_cnt == 0);

   always @(posedge clk_i) begin
      if (tree_rd_en) begin
         rd_pulses   <= rd_pulses + 1;
         tree_clause <= 8'hA0 + 8'(rd_idx);
         rd_idx      <= rd_idx + 1;
         if (tree_cnt == 0) rd_empty <= rd_empty + 1;
      end
      if (tree_load != 0)                tree_cnt <= tree_load;
      else if (tree_rd_en && tree_cnt > 0) tree_cnt <= tree_cnt - 1;
   end

   int n_chk  = 0;
   int n_fail = 0;

   logic [BW-1:0] exp_batch_q [$];
   int            exp_gnt_q   [$];
   logic [CW-1:0] exp_out_q   [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nx();
      @(negedge clk_i);
      #1;
   endtask

   function automatic logic [BW-1:0] mk_batch(input int r, input int tag);
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < CC; k++) b[k*CW +: CW] = 8'((tag << 4) | (r << 2) | k);
      return b;
   endfunction

   task automatic set_req(input int r, input int tag, input logic [CC-1:0] m);
      req_clauses[r*BW +: BW] = mk_batch(r, tag);
      req_mask[r*CC +: CC]    = m;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 30) begin
         nx();
         n++;
      end
      chk("idle_timeout", 64'(busy), 64'(0));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},    64'(req_ready),    64'(0));
      chk({tag, "_clauses"},  64'(tree_clauses), 64'(0));
      chk({tag, "_tvalid"},   64'(tree_valid),   64'(0));
      chk({tag, "_wr_en"},    64'(tree_wr_en),   64'(0));
      chk({tag, "_rd_en"},    64'(tree_rd_en),   64'(0));
      chk({tag, "_cof"},      64'(tree_cof),     64'(0));
      chk({tag, "_out_vld"},  64'(out_valid),    64'(0));
      chk({tag, "_out_data"}, 64'(out_clause),   64'(0));
      chk({tag, "_of_cnt"},   64'(of_count),     64'(0));
      chk({tag, "_busy"},     64'(busy),         64'(0));
   endtask

   initial begin
      int grants, wrs, last_g, cyc, eg, p0;
      req_valid = '0; req_mask = '0; req_clauses = '0;
      tree_of = 1'b0; tree_of2 = 1'b0; out_ready = 1'b0;

      // Reset state, with requests offered to prove ready is held low.
      #1 rst_i = 1'b1;
      req_valid = 4'hF;
      #6;
      chk_all_zero("rst");
      nx();
      rst_i = 1'b0;

      // Round-robin with all requesters held valid: r0,r1,r2,r3,r0, 6 cycles apart.
      for (int r = 0; r < NR; r++) set_req(r, 1, 4'hF);
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         exp_gnt_q.push_back(i % NR);
         exp_batch_q.push_back(mk_batch(i % NR, 1));
      end
      grants = 0; wrs = 0; last_g = -1; cyc = 0;
      #1;
      while (wrs < 5 && cyc < 80) begin
         if (req_ready != '0) begin
            if (exp_gnt_q.size() == 0) chk("extra_grant", 64'(req_ready), 64'(0));
            else begin
               eg = exp_gnt_q.pop_front();
               chk("rr_grant", 64'(req_ready), 64'(1) << eg);
            end
            if (last_g >= 0) chk("grant_interval", 64'(cyc - last_g), 64'(6));
            last_g = cyc;
            grants++;
         end
         if (tree_wr_en) begin
            if (exp_batch_q.size() != 0) chk("rr_batch", 64'(tree_clauses), 64'(exp_batch_q.pop_front()));
            chk("rr_mask", 64'(tree_valid), 64'(4'hF));
            wrs++;
         end
         nx();
         cyc++;
      end
      chk("rr_grant_count", 64'(grants), 64'(5));
      chk("rr_wr_count", 64'(wrs), 64'(5));
      req_valid = '0;
      wait_idle();

      // Zero-mask grant to r2 is discarded; r3 follows immediately.
      set_req(2, 2, 4'h0);
      set_req(3, 2, 4'hF);
      req_valid = 4'b1100;
      exp_batch_q.push_back(mk_batch(3, 2));
      #1;
      chk("zm_grant_r2", 64'(req_ready), 64'(4'b0100));
      nx();
      chk("zm_busy", 64'(busy), 64'(0));
      chk("zm_no_wr", 64'(tree_wr_en), 64'(0));
      chk("zm_grant_r3", 64'(req_ready), 64'(4'b1000));
      nx();
      req_valid = '0;
      #1;
      chk("zm_wr_r3", 64'(tree_wr_en), 64'(1));
      chk("zm_batch_r3", 64'(tree_clauses), 64'(exp_batch_q.pop_front()));
      wait_idle();

      // Overflow during WRITE count 2: burst completes, then CLEAR.
      set_req(0, 3, 4'hF);
      req_valid = 4'b0001;
      exp_batch_q.push_back(mk_batch(0, 3));
      #1;
      chk("of_grant_r0", 64'(req_ready), 64'(4'b0001));
      nx();
      req_valid = '0;
      #1;
      chk("of_wr_cnt0", 64'(tree_wr_en), 64'(1));
      chk("of_batch", 64'(tree_clauses), 64'(exp_batch_q.pop_front()));
      nx();
      chk("of_busy_cnt1", 64'(busy), 64'(1));
      nx();
      tree_of = 1'b1;
      set_req(1, 3, 4'hF);
      req_valid = 4'b0010;
      #1;
      chk("of_no_grant_cnt2", 64'(req_ready), 64'(0));
      nx();
      chk("of_count_1", 64'(of_count), 64'(1));
      chk("of_cof_cnt3", 64'(tree_cof), 64'(0));
      nx();
      chk("of_busy_cnt4", 64'(busy), 64'(1));
      chk("of_cof_cnt4", 64'(tree_cof), 64'(0));
      nx();
      chk("of_cof_pulse", 64'(tree_cof), 64'(1));
      chk("of_clear_ready", 64'(req_ready), 64'(0));
      nx();
      chk("of_idle_no_grant", 64'(req_ready), 64'(0));
      chk("of_idle_cof", 64'(tree_cof), 64'(0));
      nx();
      chk("of_cof_again", 64'(tree_cof), 64'(1));
      tree_of = 1'b0;
      exp_batch_q.push_back(mk_batch(1, 3));
      nx();
      chk("of_grant_after", 64'(req_ready), 64'(4'b0010));
      chk("of_count_hold", 64'(of_count), 64'(1));
      nx();
      req_valid = '0;
      #1;
      chk("of_wr_r1", 64'(tree_wr_en), 64'(1));
      chk("of_batch_r1", 64'(tree_clauses), 64'(exp_batch_q.pop_front()));
      wait_idle();

      // Read side: 3 clauses, consumer stalled, then drained back-to-back.
      p0 = rd_pulses;
      tree_load = 3;
      for (int k = 0; k < 3; k++) exp_out_q.push_back(8'hA0 + 8'(k));
      nx();
      tree_load = 0;
      repeat (8) nx();
      chk("rd_stall_pulses", 64'(rd_pulses - p0), 64'(2));
      chk("rd_stall_valid", 64'(out_valid), 64'(1));
      chk("rd_stall_no_rd", 64'(tree_rd_en), 64'(0));
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rd_b2b_valid", 64'(out_valid), 64'(1));
         chk("rd_data", 64'(out_clause), 64'(exp_out_q.pop_front()));
         nx();
      end
      chk("rd_drained", 64'(out_valid), 64'(0));
      chk("rd_total_pulses", 64'(rd_pulses - p0), 64'(3));
      chk("rd_while_empty", 64'(rd_empty), 64'(0));
      out_ready = 1'b0;

      // Reset at WRITE count 3 with reads in progress.
      set_req(2, 5, 4'hF);
      req_valid = 4'b0100;
      #1;
      chk("rs_grant_r2", 64'(req_ready), 64'(4'b0100));
      nx();
      req_valid = 4'hF;
      nx();
      tree_load = 2;
      nx();
      tree_load = 0;
      nx();
      chk("rs_pre_tvalid", 64'(tree_valid), 64'(4'hF));
      rst_i = 1'b1;
      #1;
      chk_all_zero("rs");
      nx();
      rst_i = 1'b0;
      #1;
      chk("rs_rr_zero", 64'(req_ready), 64'(4'b0001));
      chk("rs_of_count", 64'(of_count), 64'(0));
      nx();
      req_valid = '0;
      out_ready = 1'b1;
      wait_idle();
      repeat (4) nx();
      out_ready = 1'b0;

      // Narrow counter: 5 overflow edges saturate at 3.
      chk("sat_start", 64'(of_count2), 64'(0));
      for (int i = 0; i < 5; i++) begin
         nx();
         tree_of2 = 1'b1;
         nx();
         tree_of2 = 1'b0;
         if (i == 1) begin
            #1;
            chk("sat_two", 64'(of_count2), 64'(2));
         end
      end
      nx();
      chk("sat_three", 64'(of_count2), 64'(3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
